// File: rtl/sim_imu_pkg.sv
// Shared constants and types for the simulated IMU register-file SPI slave.
package sim_imu_pkg;

    localparam logic [7:0] CMD_RD = 8'h01;
    localparam logic [7:0] CMD_WR = 8'h02;

    // Header field positions, counted in bytes from the MSB of the header word.
    localparam int HDR_CMD_BYTE  = 0;
    localparam int HDR_ADDR_BYTE = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA
    } xfer_state_t;

    typedef enum logic {
        PH_REQUEST,
        PH_RESPONSE
    } phase_t;

    function automatic logic [7:0] reg_init(input int i);
        return 8'(i);
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser plus edge detect for the asynchronous SPI pins.
module spi_pin_sync (
    input  logic c,
    input  logic rst,
    input  logic cs,
    input  logic sck,
    input  logic mosi,
    output logic cs_lvl,
    output logic cs_fall,
    output logic cs_rise,
    output logic sck_rise,
    output logic sck_fall,
    output logic mosi_lvl
);

    logic [2:0] cs_sr;
    logic [2:0] sck_sr;
    logic [1:0] mosi_sr;

    // cs resets to its idle-high level so leaving reset never fakes a cs edge.
    always_ff @(posedge c) begin
        if (rst) begin
            cs_sr   <= 3'b111;
            sck_sr  <= 3'b000;
            mosi_sr <= 2'b00;
        end else begin
            cs_sr   <= {cs_sr[1:0], cs};
            sck_sr  <= {sck_sr[1:0], sck};
            mosi_sr <= {mosi_sr[0], mosi};
        end
    end

    assign cs_lvl   = cs_sr[1];
    assign cs_fall  = ~cs_sr[1] & cs_sr[2];
    assign cs_rise  = cs_sr[1] & ~cs_sr[2];
    assign sck_rise = sck_sr[1] & ~sck_sr[2];
    assign sck_fall = ~sck_sr[1] & sck_sr[2];
    assign mosi_lvl = mosi_sr[1];

endmodule

// File: rtl/sim_imu_regfile.sv
// IMU stand-in: SPI mode-0 slave over a byte register file, with a periodic
// sync pulse and a sample counter bumped on every sync period wrap.
module sim_imu_regfile #(
    parameter int         WORD_W      = 32,
    parameter int         NUM_REGS    = 64,
    parameter int         SYNC_PERIOD = 5000,
    parameter int         SYNC_WIDTH  = 500,
    parameter int         SPLIT_XFER  = 1,
    parameter logic [7:0] CMD_RD      = sim_imu_pkg::CMD_RD,
    parameter logic [7:0] CMD_WR      = sim_imu_pkg::CMD_WR,
    parameter logic [7:0] SAMPLE_ADDR = 8'h3F
) (
    input  logic c,
    input  logic rst,
    input  logic cs,
    input  logic sck,
    input  logic mosi,
    output logic miso,
    output logic sync_out,
    output logic xfer_done
);

    import sim_imu_pkg::*;

    localparam int B   = WORD_W / 8;
    localparam int AW  = $clog2(NUM_REGS);
    localparam int CW  = $clog2(WORD_W);
    localparam int SCW = $clog2(SYNC_PERIOD + 1);

    logic cs_lvl, cs_fall, cs_rise, sck_rise, sck_fall, mosi_lvl;

    spi_pin_sync u_pin_sync (
        .c        (c),
        .rst      (rst),
        .cs       (cs),
        .sck      (sck),
        .mosi     (mosi),
        .cs_lvl   (cs_lvl),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .mosi_lvl (mosi_lvl)
    );

    xfer_state_t       state;
    phase_t            phase;
    logic [CW-1:0]     bit_cnt;
    logic [WORD_W-1:0] rx, rx_next, tx, rd_word, wr_data;
    logic [7:0]        cmd;
    logic [7:0]        hdr_cmd;
    logic [AW-1:0]     hdr_addr, data_addr, wr_base;
    logic              load_next, wr_pend, sck_act, word_done;
    logic [7:0]        regs [NUM_REGS];
    logic [SCW-1:0]    sync_cnt;
    logic              sample_tick;

    always_comb begin
        sck_act   = sck_rise & ~cs_lvl & (state != ST_IDLE);
        rx_next   = {rx[WORD_W-2:0], mosi_lvl};
        word_done = sck_act && (bit_cnt == CW'(WORD_W - 1));
        hdr_cmd   = rx_next[WORD_W-1-8*HDR_CMD_BYTE -: 8];
        hdr_addr  = rx_next[WORD_W-8-8*HDR_ADDR_BYTE +: AW];
    end

    // Word presented to the tx shifter: bytes from data_addr upward, wrapping.
    always_comb begin
        rd_word = '0;
        for (int j = 0; j < B; j++)
            rd_word[WORD_W-1-8*j -: 8] = regs[data_addr + AW'(j)];
    end

    always_ff @(posedge c) begin
        if (rst) begin
            state     <= ST_IDLE;
            phase     <= PH_REQUEST;
            bit_cnt   <= '0;
            rx        <= '0;
            tx        <= '0;
            cmd       <= '0;
            data_addr <= '0;
            load_next <= 1'b0;
            wr_pend   <= 1'b0;
            wr_data   <= '0;
            wr_base   <= '0;
            xfer_done <= 1'b0;
        end else begin
            xfer_done <= cs_rise;
            wr_pend   <= 1'b0;
            if (cs_rise) begin
                state     <= ST_IDLE;
                tx        <= '0;
                load_next <= 1'b0;
            end else if (cs_fall) begin
                bit_cnt   <= '0;
                rx        <= '0;
                load_next <= 1'b0;
                if (SPLIT_XFER != 0 && phase == PH_RESPONSE) begin
                    state <= ST_DATA;
                    tx    <= (cmd == CMD_RD) ? rd_word : '0;
                end else begin
                    state <= ST_HDR;
                    tx    <= '0;
                end
                if (SPLIT_XFER != 0)
                    phase <= (phase == PH_REQUEST) ? PH_RESPONSE : PH_REQUEST;
            end else begin
                if (sck_act) begin
                    rx      <= rx_next;
                    bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
                    if (word_done) begin
                        if (state == ST_HDR) begin
                            cmd       <= hdr_cmd;
                            data_addr <= hdr_addr;
                            // A split request carries only the header; the rest is ignored.
                            if (SPLIT_XFER != 0) begin
                                state <= ST_IDLE;
                            end else begin
                                state     <= ST_DATA;
                                load_next <= 1'b1;
                            end
                        end else begin
                            data_addr <= data_addr + AW'(B);
                            load_next <= 1'b1;
                            if (cmd == CMD_WR) begin
                                wr_pend <= 1'b1;
                                wr_data <= rx_next;
                                wr_base <= data_addr;
                            end
                        end
                    end
                end
                if (sck_fall && !cs_lvl && state == ST_DATA) begin
                    if (load_next) begin
                        tx        <= (cmd == CMD_RD) ? rd_word : '0;
                        load_next <= 1'b0;
                    end else begin
                        tx <= tx << 1;
                    end
                end
            end
        end
    end

    assign miso = tx[WORD_W-1];

    always_ff @(posedge c) begin
        if (rst)
            sync_cnt <= '0;
        else if (sample_tick)
            sync_cnt <= '0;
        else
            sync_cnt <= sync_cnt + 1'b1;
    end

    assign sample_tick = (sync_cnt == SCW'(SYNC_PERIOD));
    assign sync_out    = (sync_cnt < SCW'(SYNC_WIDTH));

    // The SPI write is issued after the increment so it wins on a shared cycle.
    always_ff @(posedge c) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= reg_init(i);
        end else begin
            if (sample_tick)
                regs[SAMPLE_ADDR[AW-1:0]] <= regs[SAMPLE_ADDR[AW-1:0]] + 8'd1;
            if (wr_pend) begin
                for (int j = 0; j < B; j++)
                    regs[wr_base + AW'(j)] <= wr_data[WORD_W-1-8*j -: 8];
            end
        end
    end

endmodule

// File: tb/tb_sim_imu_regfile.sv
// Directed bench for sim_imu_regfile: split-mode and single-mode instances share sck/mosi.
module tb_sim_imu_regfile;

    logic c    = 1'b0;
    logic rst  = 1'b1;
    logic cs_a = 1'b1;
    logic cs_b = 1'b1;
    logic sck  = 1'b0;
    logic mosi = 1'b0;
    logic miso_a, sync_out_a, xfer_done_a;
    logic miso_b, sync_out_b, xfer_done_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hi_cnt = 0;
    int xd_a   = 0;
    int xd_b   = 0;
    logic [63:0] w;

    always #5 c = ~c;

    sim_imu_regfile #(.SPLIT_XFER(1)) dut_a (
        .c(c), .rst(rst), .cs(cs_a), .sck(sck), .mosi(mosi),
        .miso(miso_a), .sync_out(sync_out_a), .xfer_done(xfer_done_a)
    );

    sim_imu_regfile #(.SPLIT_XFER(0)) dut_b (
        .c(c), .rst(rst), .cs(cs_b), .sck(sck), .mosi(mosi),
        .miso(miso_b), .sync_out(sync_out_b), .xfer_done(xfer_done_b)
    );

    always @(posedge c) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
        if (xfer_done_a) xd_a <= xd_a + 1;
        if (xfer_done_b) xd_b <= xd_b + 1;
    end

    // Counts sync_out high over exactly three 5001-cycle periods after reset.
    always @(negedge c) begin
        if (rst)
            hi_cnt <= 0;
        else if (cyc >= 1 && cyc <= 15003 && sync_out_a)
            hi_cnt <= hi_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge c);
        rst = 1'b1;
        repeat (3) @(negedge c);
        #2 rst = 1'b0;
    endtask

    // One CS frame of n bits, MSB first; miso sampled just before each sck rise.
    // last_at > 0 holds the final sck rise until the cycle counter reaches it.
    task automatic spi(input bit sel, input logic [63:0] data, input int n,
                       input int last_at, output logic [63:0] got);
        got = '0;
        @(negedge c);
        if (sel) cs_b = 1'b0; else cs_a = 1'b0;
        #100;
        for (int i = 0; i < n; i++) begin
            mosi = data[n-1-i];
            #40;
            if (i == n - 1 && last_at > 0) begin
                while (cyc < last_at) @(negedge c);
                check("wrap_align", 64'(cyc), 64'(last_at));
            end
            got = {got[62:0], (sel ? miso_b : miso_a)};
            sck = 1'b1;
            #80;
            sck = 1'b0;
            #40;
        end
        #60;
        if (sel) cs_b = 1'b1; else cs_a = 1'b1;
        #200;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (4) @(negedge c);
        check("rst_miso", 64'(miso_a), 64'd0);
        check("rst_sync_out", 64'(sync_out_a), 64'd1);
        check("rst_xfer_done", 64'(xfer_done_a), 64'd0);
        #2 rst = 1'b0;

        spi(0, 64'h01100000, 32, 0, w);
        check("req_miso", w, 64'd0);
        spi(0, 64'd0, 64, 0, w);
        check("rd_two_words", w, 64'h10111213_14151617);
        check("xfer_done_cnt", 64'(xd_a), 64'd2);
        check("idle_miso", 64'(miso_a), 64'd0);

        spi(0, 64'h02200000, 32, 0, w);
        spi(0, 64'hAABBCCDD, 32, 0, w);
        check("wr_miso", w, 64'd0);
        spi(0, 64'h01200000, 32, 0, w);
        spi(0, 64'd0, 64, 0, w);
        check("wr_readback", w, 64'hAABBCCDD_24252627);

        spi(0, 64'h02300000, 32, 0, w);
        spi(0, 64'hDEADB, 20, 0, w);
        check("partial_xfer_done", 64'(xd_a), 64'd8);
        spi(0, 64'h01300000, 32, 0, w);
        spi(0, 64'd0, 32, 0, w);
        check("partial_no_write", w, 64'h30313233);

        spi(1, 64'h01080000_00000000, 64, 0, w);
        check("single_rd", w, 64'h00000000_08090A0B);
        check("single_xfer_done", 64'(xd_b), 64'd1);
        check("split_ignores_other_cs", 64'(xd_a), 64'd10);

        do_reset();
        spi(0, 64'h013E0000, 32, 0, w);
        spi(0, 64'd0, 32, 0, w);
        check("rd_addr_wrap", w, 64'h3E3F0001);

        do_reset();
        spi(0, 64'h023F0000, 32, 0, w);
        spi(0, 64'h00000102, 32, 0, w);
        while (cyc < 15100) @(negedge c);
        check("sync_high_cycles", 64'(hi_cnt), 64'd1500);
        spi(0, 64'h013F0000, 32, 0, w);
        spi(0, 64'd0, 32, 0, w);
        check("sample_after_3_wraps", w, 64'h03000102);

        while (cyc < 18800) @(negedge c);
        spi(0, 64'h023F0000, 32, 0, w);
        spi(0, 64'h55000102, 32, 20000, w);
        spi(0, 64'h013F0000, 32, 0, w);
        spi(0, 64'd0, 32, 0, w);
        check("sample_write_wins", w, 64'h55000102);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
